// File: rtl/mmio_bus_ctrl.sv
// CPU-side bus controller: routes single accesses to an internal RAM, a local
// LED register, or one of N_SLOTS external MMIO slots with a ready timeout.

module mmio_bus_ctrl_ram #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter     ROMFILE = ""
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_reg;

  // Not reset: contents must survive a controller reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata_reg <= mem[addr];
  end

  assign rdata = rdata_reg;
endmodule

module mmio_bus_ctrl #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 8,
  parameter int                N_SLOTS  = 4,
  parameter logic [ADDR_W-1:0] LED_ADDR = ADDR_W'(8'hF0),
  parameter int                TIMEOUT  = 15,
  parameter                    ROMFILE  = ""
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req,
  input  logic                      we,
  input  logic                      mmio,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [DATA_W-1:0]         din,
  output logic                      ack,
  output logic                      err,
  output logic                      busy,
  output logic [DATA_W-1:0]         dout,
  output logic [7:0]                o_leds,
  output logic [N_SLOTS-1:0]        p_sel,
  output logic                      p_we,
  output logic [ADDR_W-1:0]         p_addr,
  output logic [DATA_W-1:0]         p_din,
  input  logic [N_SLOTS*DATA_W-1:0] p_dout,
  input  logic [N_SLOTS-1:0]        p_ready
);
  localparam int              SW         = ADDR_W - 4;
  localparam logic [SW-1:0]   SLOT_LIMIT = SW'(N_SLOTS);
  localparam logic [7:0]      TO_LAST    = 8'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, RAM_RD, RAM_WR, SLOT, LOCAL, DONE} state_t;

  state_t              state_reg, state_next;
  logic [7:0]          cnt_reg, cnt_next;
  logic                we_reg, we_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   din_reg, din_next;
  logic [DATA_W-1:0]   dout_reg, dout_next;
  logic                ack_reg, ack_next;
  logic                err_reg, err_next;
  logic                busy_reg, busy_next;
  logic [7:0]          leds_reg, leds_next;
  logic [N_SLOTS-1:0]  sel_reg, sel_next;
  logic [N_SLOTS-1:0]  in_sel;
  logic [DATA_W-1:0]   slot_masked [N_SLOTS];
  logic [DATA_W-1:0]   slot_rdata;
  logic [DATA_W-1:0]   ram_rdata;
  logic                ram_we, ready_hit, in_is_led, in_is_slot;

  genvar gi;
  generate
    for (gi = 0; gi < N_SLOTS; gi++) begin : g_slot
      assign in_sel[gi]      = (addr[ADDR_W-1:4] == SW'(gi));
      assign slot_masked[gi] = sel_reg[gi] ? p_dout[gi*DATA_W +: DATA_W] : '0;
    end
  endgenerate

  always_comb begin
    slot_rdata = '0;
    for (int i = 0; i < N_SLOTS; i++) slot_rdata |= slot_masked[i];
  end

  assign in_is_led  = (addr == LED_ADDR);
  assign in_is_slot = (addr[ADDR_W-1:4] < SLOT_LIMIT);
  // Only the selected slot's ready matters; sel_reg is zero outside SLOT.
  assign ready_hit  = |(p_ready & sel_reg);
  // RAM phases reuse the wait counter: cycle 0 issues, cycle 1 completes.
  assign ram_we     = (state_reg == RAM_WR) && (cnt_reg == 8'd0);

  mmio_bus_ctrl_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ROMFILE(ROMFILE)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (addr_reg),
    .wdata (din_reg),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      din_reg   <= '0;
      dout_reg  <= '0;
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      leds_reg  <= '0;
      sel_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      din_reg   <= din_next;
      dout_reg  <= dout_next;
      ack_reg   <= ack_next;
      err_reg   <= err_next;
      busy_reg  <= busy_next;
      leds_reg  <= leds_next;
      sel_reg   <= sel_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    din_next   = din_reg;
    dout_next  = dout_reg;
    ack_next   = 1'b0;
    err_next   = err_reg;
    busy_next  = busy_reg;
    leds_next  = leds_reg;
    sel_next   = sel_reg;
    case (state_reg)
      IDLE: begin
        if (req) begin
          we_next   = we;
          addr_next = addr;
          din_next  = din;
          busy_next = 1'b1;
          cnt_next  = '0;
          err_next  = 1'b0;
          if (!mmio)           state_next = we ? RAM_WR : RAM_RD;
          else if (in_is_led)  state_next = LOCAL;
          else if (in_is_slot) begin
            state_next = SLOT;
            sel_next   = in_sel;
          end
          // Unmapped MMIO also completes through LOCAL, which re-checks the address.
          else                 state_next = LOCAL;
        end
      end
      RAM_RD, RAM_WR: begin
        if (cnt_reg == 8'd0) begin
          cnt_next = 8'd1;
        end else begin
          state_next = DONE;
          ack_next   = 1'b1;
          if (state_reg == RAM_RD) dout_next = ram_rdata;
        end
      end
      SLOT: begin
        if (ready_hit) begin
          if (!we_reg) dout_next = slot_rdata;
          sel_next   = '0;
          ack_next   = 1'b1;
          state_next = DONE;
        end else if (cnt_reg + 8'd1 == TO_LAST) begin
          if (!we_reg) dout_next = '0;
          sel_next   = '0;
          ack_next   = 1'b1;
          err_next   = 1'b1;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      LOCAL: begin
        ack_next   = 1'b1;
        state_next = DONE;
        if (addr_reg == LED_ADDR) begin
          if (we_reg) leds_next = din_reg[7:0];
          else        dout_next = DATA_W'(leds_reg);
        end else begin
          err_next = 1'b1;
          if (!we_reg) dout_next = '0;
        end
      end
      DONE: begin
        busy_next  = 1'b0;
        err_next   = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign ack    = ack_reg;
  assign err    = err_reg;
  assign busy   = busy_reg;
  assign dout   = dout_reg;
  assign o_leds = leds_reg;
  assign p_sel  = sel_reg;
  assign p_we   = we_reg;
  assign p_addr = addr_reg;
  assign p_din  = din_reg;
endmodule

// File: doc/mmio_bus_ctrl.md
MMIO_BUS_CTRL -- requirements
Module: mmio_bus_ctrl

Interface
REQ-001 Parameter DATA_W, default 8: data width of CPU port, RAM and peripheral slots.
REQ-002 Parameter ADDR_W, default 8: address width; RAM depth is 2^ADDR_W words.
REQ-003 Parameter N_SLOTS, default 4, legal 1..8: number of external MMIO peripheral slots.
REQ-004 Parameter LED_ADDR, default 8'hF0: MMIO address of the internal LED register.
REQ-005 Parameter TIMEOUT, default 15, legal 1..255: max cycles to wait for slot p_ready.
REQ-006 Parameter ROMFILE, default "": RAM init file, passed to the internal ram instance.
REQ-007 clk  in  1  single clock; all state changes on its rising edge.
REQ-008 rst  in  1  asynchronous, active-low reset (asserted when 0).
REQ-009 req  in  1  CPU access request, sampled only while idle.
REQ-010 we  in  1  1 = write, 0 = read; sampled with req.
REQ-011 mmio  in  1  1 = MMIO space, 0 = RAM space; sampled with req.
REQ-012 addr  in  ADDR_W  access address; sampled with req.
REQ-013 din  in  DATA_W  write data; sampled with req.
REQ-014 ack  out  1  one-cycle completion pulse.
REQ-015 err  out  1  valid with ack: 1 = unmapped address or slot timeout.
REQ-016 busy  out  1  1 from accept edge until the cycle after ack.
REQ-017 dout  out  DATA_W  read data, held from ack until next ack.
REQ-018 o_leds  out  8  LED register contents.
REQ-019 p_sel  out  N_SLOTS  one-hot slot select, held during a slot access.
REQ-020 p_we, p_addr[ADDR_W], p_din[DATA_W]  out  latched we/addr/din driven to the slots.
REQ-021 p_dout  in  N_SLOTS*DATA_W  slot read data, slot i at bits [i*DATA_W +: DATA_W].
REQ-022 p_ready  in  N_SLOTS  per-slot completion, sampled only for the selected slot.

Function
REQ-023 FSM states IDLE, RAM_RD, RAM_WR, SLOT, LOCAL, DONE; one transaction at a time, no pipelining.
REQ-024 IDLE with req=1 at edge E0: latch we/mmio/addr/din, decode, busy=1; req ignored in all non-IDLE states.
REQ-025 Decode priority: mmio=0 -> RAM; mmio=1 and addr==LED_ADDR -> LOCAL; mmio=1 and addr[ADDR_W-1:4]<N_SLOTS -> SLOT index addr[ADDR_W-1:4]; otherwise unmapped.
REQ-026 RAM write: ram write_en high only for the cycle after E0; ack at cycle E0+2, err=0, dout unchanged.
REQ-027 RAM read: registered RAM read; dout updated and ack high at cycle E0+2, err=0.
REQ-028 LOCAL: write loads o_leds with din[7:0]; read returns o_leds zero-extended to DATA_W; ack at E0+1.
REQ-029 SLOT: p_sel[i]=1 from E0 until the edge p_ready[i]=1 is seen; that edge captures p_dout slice into dout (reads only), clears p_sel, ack next cycle, err=0.
REQ-030 p_ready of unselected slots, or while no slot selected, is ignored.
REQ-031 Slot timeout: wait counter starts 0 at E0, increments per SLOT cycle; reaching TIMEOUT without p_ready -> p_sel cleared, dout=0 for reads, ack=1 with err=1.
REQ-032 p_ready arriving on the same edge the counter reaches TIMEOUT counts as success (err=0).
REQ-033 Unmapped: no side effects, ack at E0+1 with err=1, dout=0 for reads and unchanged for writes.
REQ-034 DONE: ack deasserts; busy deasserts; FSM returns IDLE; next req sampled at following edge.
REQ-035 Back-to-back: req held high continuously yields a new accept every transaction, min two-cycle gap between acks.

Reset
REQ-036 rst=0 asynchronously forces IDLE, ack=0, err=0, busy=0, dout=0, o_leds=0, p_sel=0, p_we=0, timeout counter=0.
REQ-037 Reset mid-transaction drops it: no ack ever issued for it; RAM contents keep any write already committed.
REQ-038 RAM contents are not cleared by reset.

Verification
REQ-039 RAM write 8'h5A to 8'h22, then read 8'h22 -> each ack at E0+2, read dout=8'h5A, err=0.
REQ-040 MMIO write 8'hA5 to LED_ADDR -> o_leds=8'hA5 at E0+1; read back dout=8'hA5, ack at E0+1.
REQ-041 Slot 2 read at 8'h23, p_ready[2] after 3 cycles with p_dout slice 8'h3C -> p_sel=4'b0100 until then, dout=8'h3C, err=0.
REQ-042 Slot 1 read, p_ready never asserted -> ack with err=1 after TIMEOUT=15 cycles, dout=0, p_sel=0.
REQ-043 MMIO read 8'h70 with N_SLOTS=4 -> ack at E0+1, err=1, dout=0, no p_sel activity.
REQ-044 rst=0 during slot wait, after LED write 8'hFF -> no ack, p_sel=0, o_leds=0 immediately, next req served normally.
